// File: rtl/lcd_sequencer.sv
// Character LCD sequencer: power-up wait, four-command init, then mirrors a
// 2x16 character buffer onto the display over the strobe/busy handshake.
module lcd_sequencer #(
  parameter int unsigned POWERUP_CYCLES = 750000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_wr_en,
  input  logic [4:0] i_wr_addr,
  input  logic [7:0] i_wr_char,
  input  logic       i_clear,
  input  logic       i_lcd_busy,
  output logic       o_lcd_strobe,
  output logic       o_lcd_cmd_sel,
  output logic [7:0] o_lcd_data,
  output logic       o_init_done,
  output logic       o_refresh_active
);

  localparam int unsigned DEPTH = 32;
  localparam logic [7:0]  BLANK = 8'h20;

  typedef enum logic [2:0] {
    S_PWRUP,
    S_INIT,
    S_WAIT,
    S_IDLE,
    S_ADDR,
    S_CHAR
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_init_idx;
  logic             r_line;
  logic [3:0]       r_col;
  logic             r_wait_first;
  logic             r_dirty;
  logic [7:0]       r_buf [DEPTH];
  logic [7:0]       w_init_cmd;
  logic             w_host_wr;

  assign w_host_wr = i_wr_en | i_clear;

  // Init command ROM
  always_comb begin
    w_init_cmd = 8'h38;
    case (r_init_idx)
      2'd0:    w_init_cmd = 8'h38;
      2'd1:    w_init_cmd = 8'h0C;
      2'd2:    w_init_cmd = 8'h06;
      default: w_init_cmd = 8'h01;
    endcase
  end

  // Character buffer: clear first, so a same-cycle write overrides its cell
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= BLANK;
    end else begin
      if (i_clear) begin
        for (int i = 0; i < DEPTH; i++) r_buf[i] <= BLANK;
      end
      if (i_wr_en) r_buf[i_wr_addr] <= i_wr_char;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= S_PWRUP;
      r_cnt            <= '0;
      r_init_idx       <= '0;
      r_line           <= 1'b0;
      r_col            <= '0;
      r_wait_first     <= 1'b0;
      r_dirty          <= 1'b1;
      o_lcd_strobe     <= 1'b0;
      o_lcd_cmd_sel    <= 1'b0;
      o_lcd_data       <= '0;
      o_init_done      <= 1'b0;
      o_refresh_active <= 1'b0;
    end else begin
      o_lcd_strobe <= 1'b0;
      case (r_state)
        S_PWRUP: begin
          if (r_cnt == CNT_W'(POWERUP_CYCLES - 1)) begin
            r_state    <= S_INIT;
            r_init_idx <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_INIT: begin
          if (!i_lcd_busy) begin
            o_lcd_strobe  <= 1'b1;
            o_lcd_cmd_sel <= 1'b1;
            o_lcd_data    <= w_init_cmd;
            r_wait_first  <= 1'b1;
            r_state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Busy rises one cycle late, so the strobe cycle itself is skipped.
          // The held cmd_sel/init_done tell which step the transfer belonged to.
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (!i_lcd_busy) begin
            if (!o_init_done) begin
              if (r_init_idx == 2'd3) begin
                o_init_done <= 1'b1;
                r_state     <= S_IDLE;
              end else begin
                r_init_idx <= r_init_idx + 2'd1;
                r_state    <= S_INIT;
              end
            end else if (o_lcd_cmd_sel) begin
              r_col   <= '0;
              r_state <= S_CHAR;
            end else if (r_col == 4'd15) begin
              if (!r_line) begin
                r_line  <= 1'b1;
                r_state <= S_ADDR;
              end else begin
                o_refresh_active <= 1'b0;
                r_state          <= S_IDLE;
              end
            end else begin
              r_col   <= r_col + 4'd1;
              r_state <= S_CHAR;
            end
          end
        end
        S_IDLE: begin
          if (r_dirty) begin
            r_dirty          <= 1'b0;
            o_refresh_active <= 1'b1;
            r_line           <= 1'b0;
            r_state          <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (!i_lcd_busy) begin
            o_lcd_strobe  <= 1'b1;
            o_lcd_cmd_sel <= 1'b1;
            o_lcd_data    <= r_line ? 8'hC0 : 8'h80;
            r_wait_first  <= 1'b1;
            r_state       <= S_WAIT;
          end
        end
        S_CHAR: begin
          if (!i_lcd_busy) begin
            o_lcd_strobe  <= 1'b1;
            o_lcd_cmd_sel <= 1'b0;
            o_lcd_data    <= r_buf[{r_line, r_col}];
            r_wait_first  <= 1'b1;
            r_state       <= S_WAIT;
          end
        end
        default: r_state <= S_PWRUP;
      endcase
      // Host writes win over the IDLE dirty clear
      if (w_host_wr) r_dirty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Bench for lcd_sequencer: busy-model LCD, strobe log, buffer model and
// table/random/hand-written scenarios.
module tb_lcd_sequencer;

  localparam int unsigned PWR = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [4:0] wr_addr = '0;
  logic [7:0] wr_char = '0;
  logic       clear = 1'b0;
  logic       lcd_busy = 1'b0;
  logic       lcd_strobe, lcd_cmd_sel, init_done, refresh_active;
  logic [7:0] lcd_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [8:0] q_obs[$];
  int         q_cyc[$];
  logic [8:0] exp_q[$];
  logic [8:0] last_frame [34];
  int         last_cyc [34];
  logic [7:0] mbuf [32];
  int         busy_cnt = 0;
  int         long_idx = -1;
  logic       prev_strobe = 1'b0;

  typedef struct {
    logic       clr;
    logic       wr;
    logic [4:0] addr;
    logic [7:0] ch;
    logic [4:0] probe;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs [6];

  lcd_sequencer #(.POWERUP_CYCLES(PWR), .CNT_W(20)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_wr_en         (wr_en),
    .i_wr_addr       (wr_addr),
    .i_wr_char       (wr_char),
    .i_clear         (clear),
    .i_lcd_busy      (lcd_busy),
    .o_lcd_strobe    (lcd_strobe),
    .o_lcd_cmd_sel   (lcd_cmd_sel),
    .o_lcd_data      (lcd_data),
    .o_init_done     (init_done),
    .o_refresh_active(refresh_active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // LCD timing model: log each strobe, raise busy for a few cycles after it
  always @(negedge clk) begin
    if (lcd_strobe) begin
      check("busy_at_strobe", int'(lcd_busy), 0);
      check("strobe_width", int'(prev_strobe), 0);
      q_obs.push_back({lcd_cmd_sel, lcd_data});
      q_cyc.push_back(cyc);
      busy_cnt = (q_obs.size() == long_idx) ? 50 : 3;
      lcd_busy = 1'b1;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) lcd_busy = 1'b0;
    end
    prev_strobe = lcd_strobe;
  end

  function automatic int pos_of(input logic [4:0] a);
    return (a < 5'd16) ? int'(a) + 1 : int'(a) + 2;
  endfunction

  function automatic void mk_refresh();
    exp_q.delete();
    for (int l = 0; l < 2; l++) begin
      exp_q.push_back((l == 0) ? 9'h180 : 9'h1C0);
      for (int c = 0; c < 16; c++) exp_q.push_back({1'b0, mbuf[l*16+c]});
    end
  endfunction

  task automatic host(input logic c, input logic w, input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    clear = c; wr_en = w; wr_addr = a; wr_char = d;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    if (c) for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    if (w) mbuf[a] = d;
  endtask

  task automatic wait_obs(input int n, input string name);
    int k = 0;
    while (q_obs.size() < n && k < 4000) begin @(negedge clk); k++; end
    check({name, "_arrived"}, int'(q_obs.size() >= n), 1);
  endtask

  task automatic expect_frame(input string name);
    int n = exp_q.size();
    wait_obs(n, name);
    for (int i = 0; i < n; i++) begin
      last_frame[i] = (i < q_obs.size()) ? q_obs[i] : 9'h1FF;
      last_cyc[i]   = (i < q_cyc.size()) ? q_cyc[i] : -1;
      check($sformatf("%s[%0d]", name, i), int'(last_frame[i]), int'(exp_q[i]));
    end
    for (int i = 0; i < n && q_obs.size() > 0; i++) begin
      void'(q_obs.pop_front());
      void'(q_cyc.pop_front());
    end
  endtask

  task automatic expect_quiet(input string name);
    repeat (100) @(negedge clk);
    check({name, "_no_extra"}, q_obs.size(), 0);
    check({name, "_refresh_off"}, int'(refresh_active), 0);
  endtask

  // Reset, power-up silence, init commands and the boot refresh
  task automatic do_reset(input string name);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check({name, "_rst_strobe"}, int'(lcd_strobe), 0);
    check({name, "_rst_cmd_sel"}, int'(lcd_cmd_sel), 0);
    check({name, "_rst_data"}, int'(lcd_data), 0);
    check({name, "_rst_init_done"}, int'(init_done), 0);
    check({name, "_rst_refresh"}, int'(refresh_active), 0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    q_obs.delete(); q_cyc.delete();
    repeat (PWR) @(negedge clk);
    check({name, "_pwrup_silent"}, q_obs.size(), 0);
    exp_q.delete();
    exp_q.push_back(9'h138); exp_q.push_back(9'h10C);
    exp_q.push_back(9'h106); exp_q.push_back(9'h101);
    expect_frame({name, "_init"});
    check({name, "_init_done_late"}, int'(init_done), 0);
    mk_refresh();
    expect_frame({name, "_boot_refresh"});
    check({name, "_init_done_set"}, int'(init_done), 1);
    check({name, "_refresh_on"}, int'(refresh_active), 1);
    expect_quiet({name, "_boot"});
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{clr: 1'b0, wr: 1'b1, addr: 5'd17, ch: 8'h41, probe: 5'd17, exp: 8'h41};
    vecs[1] = '{clr: 1'b0, wr: 1'b1, addr: 5'd31, ch: 8'h5A, probe: 5'd17, exp: 8'h41};
    vecs[2] = '{clr: 1'b1, wr: 1'b1, addr: 5'd5,  ch: 8'h31, probe: 5'd5,  exp: 8'h31};
    vecs[3] = '{clr: 1'b0, wr: 1'b1, addr: 5'd0,  ch: 8'h7E, probe: 5'd17, exp: 8'h20};
    vecs[4] = '{clr: 1'b1, wr: 1'b0, addr: 5'd9,  ch: 8'h00, probe: 5'd5,  exp: 8'h20};
    vecs[5] = '{clr: 1'b0, wr: 1'b1, addr: 5'd15, ch: 8'h42, probe: 5'd15, exp: 8'h42};

    do_reset("boot");

    // Table: host writes/clears, each followed by one full refresh
    for (int i = 0; i < 6; i++) begin
      host(vecs[i].clr, vecs[i].wr, vecs[i].addr, vecs[i].ch);
      mk_refresh();
      expect_frame($sformatf("vec%0d", i));
      check($sformatf("vec%0d_probe", i), int'(last_frame[pos_of(vecs[i].probe)]),
            int'({1'b0, vecs[i].exp}));
      expect_quiet($sformatf("vec%0d", i));
    end

    // Long busy: strobe #7 must follow the busy drop by exactly the state step
    long_idx = 6;
    host(1'b0, 1'b1, 5'd9, 8'h48);
    mk_refresh();
    expect_frame("long_busy");
    check("long_busy_gap", last_cyc[6] - last_cyc[5], 52);
    long_idx = -1;
    expect_quiet("long_busy");

    // Write to an already-sent cell while line 1 is going out
    host(1'b0, 1'b1, 5'd3, 8'h51);
    mk_refresh();
    wait_obs(20, "midwrite_line1");
    host(1'b0, 1'b1, 5'd0, 8'h5A);
    expect_frame("midwrite_first");
    check("midwrite_first_addr0", int'(last_frame[1]), 32'h20);
    mk_refresh();
    expect_frame("midwrite_second");
    check("midwrite_second_addr0", int'(last_frame[1]), 32'h5A);
    expect_quiet("midwrite");

    // Random host traffic; the last refresh must match the final buffer
    q_obs.delete(); q_cyc.delete();
    for (int t = 0; t < 60; t++) begin
      int gap;
      gap = int'($urandom_range(1, 20));
      repeat (gap) @(negedge clk);
      host($urandom_range(0, 15) == 0, $urandom_range(0, 7) != 0,
           5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
    end
    begin
      int idle = 0;
      int k = 0;
      int last_n = q_obs.size();
      int frames;
      int base;
      while (idle < 300 && k < 20000) begin
        @(negedge clk);
        k++;
        if (q_obs.size() != last_n || refresh_active) begin
          idle = 0;
          last_n = q_obs.size();
        end else begin
          idle++;
        end
      end
      check("rand_settle", int'(idle >= 300), 1);
      check("rand_frame_multiple", q_obs.size() % 34, 0);
      frames = q_obs.size() / 34;
      for (int f = 0; f < frames; f++) begin
        check($sformatf("rand_hdr0_f%0d", f), int'(q_obs[f*34]), 32'h180);
        check($sformatf("rand_hdr1_f%0d", f), int'(q_obs[f*34+17]), 32'h1C0);
      end
      mk_refresh();
      base = (q_obs.size() >= 34) ? q_obs.size() - 34 : 0;
      for (int i = 0; i < 34; i++) begin
        check($sformatf("rand_final[%0d]", i),
              (base + i < q_obs.size()) ? int'(q_obs[base+i]) : -1, int'(exp_q[i]));
      end
    end

    // Reset while the refresh is about to send line 0 col 7
    q_obs.delete(); q_cyc.delete();
    host(1'b0, 1'b1, 5'd20, 8'h52);
    wait_obs(8, "rst_mid_col6");
    begin
      int k = 0;
      int target = (q_cyc.size() >= 8) ? q_cyc[7] + 4 : cyc;
      while (cyc < target && k < 100) begin @(negedge clk); k++; end
    end
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_mid_strobe_stop", q_obs.size(), 8);
    check("rst_mid_init_done", int'(init_done), 0);
    do_reset("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Owns the character LCD timing block: runs the power-up init sequence, then mirrors a 2x16 character buffer onto the display.
- Host logic (band/frequency readout, status) writes characters into the buffer at any time.
- The sequencer issues the commands and characters one at a time over the strobe/busy handshake of the LCD timing block.
- Sits between the SDR control logic and the LCD timing module.

Parameters:
POWERUP_CYCLES, 750000, clk cycles to wait after reset before the first command (15 ms at 50 MHz)
CNT_W, 20, width of the power-up counter; must hold POWERUP_CYCLES

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_en  in  1  buffer write strobe, one cycle
wr_addr  in  5  buffer address; 0-15 = line 0, 16-31 = line 1
wr_char  in  8  ASCII character to write
clear  in  1  one-cycle pulse: fill buffer with 0x20
lcd_busy  in  1  busy from LCD timing block
lcd_strobe  out  1  one-cycle transfer request to LCD timing block
lcd_cmd_sel  out  1  1 = command byte, 0 = character byte
lcd_data  out  8  byte to transfer
init_done  out  1  high once init sequence is complete
refresh_active  out  1  high while a buffer refresh is in progress

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - lcd_strobe=0, lcd_cmd_sel=0, lcd_data=0x00, init_done=0, refresh_active=0.
  - All 32 buffer entries = 0x20. Dirty flag = 1.
  - State = PWRUP, counter = 0.
- rst asserted mid-operation aborts any transfer at once; no further strobe until PWRUP completes again.
- Buffer: 32x8 registers.
  - wr_en writes wr_char to wr_addr next edge.
  - clear sets all 32 entries to 0x20 in one cycle.
  - clear and wr_en in the same cycle: clear applies, then wr_en overrides its address.
  - Any wr_en or clear sets dirty.
  - Writes are accepted in every state, including PWRUP and during a refresh.
- Handshake:
  - lcd_strobe is a single-cycle pulse, issued only in a cycle where lcd_busy=0.
  - lcd_data and lcd_cmd_sel are valid in the strobe cycle and held until the next strobe.
  - After a strobe, the FSM enters WAIT. The first WAIT cycle ignores lcd_busy, because the timing block raises it one cycle after the strobe.
  - WAIT then exits on the first cycle with lcd_busy=0.
- FSM states:
  - PWRUP: count to POWERUP_CYCLES-1, then go to INIT with index 0.
  - INIT: issue commands in order, all with cmd_sel=1: 0x38 (8-bit, 2 lines), 0x0C (display on, no cursor), 0x06 (entry increment), 0x01 (clear). Each is followed by WAIT. After the 4th WAIT, set init_done=1 and go to IDLE.
  - IDLE: if dirty=1, clear dirty, set refresh_active=1, line=0, go to ADDR.
  - Dirty-clear and a same-cycle wr_en/clear: the set wins, so dirty stays 1 and a second refresh follows.
  - ADDR: issue command 0x80 (line 0) or 0xC0 (line 1), then WAIT, then CHAR with col=0.
  - CHAR: issue buffer[line*16+col] with cmd_sel=0, then WAIT.
    - col increments; after col=15, go to ADDR for line 1.
    - After line 1 col 15, clear refresh_active and go to IDLE.
  - Characters are read from the buffer at strobe time, so a write landing mid-refresh shows if its cell is not yet sent. The dirty flag guarantees a later full refresh in all cases.
- Transfer counts:
  - Init: exactly 4 strobes.
  - Each refresh: exactly 34 strobes (2 address commands + 32 characters).
- init_done stays 1 until rst.

Test Plan:
1. Power-up and init. Setup: POWERUP_CYCLES=10, bench busy model holding busy 3 cycles after each strobe, rst pulse. Required:
   - No strobe for 10 cycles after rst deasserts.
   - Then 4 command strobes 0x38, 0x0C, 0x06, 0x01 (cmd_sel=1), with init_done rising after the last busy drop.
   - Then an immediate refresh of 34 strobes: 0x80, 16x 0x20, 0xC0, 16x 0x20.
2. Single write. Stimulus: after idle, wr_en addr=17 char=0x41. Required: refresh_active=1 and a 34-strobe refresh in which the 2nd character after 0xC0 is 0x41, all others 0x20; then refresh_active=0 and no further strobes.
3. Handshake. Stimulus: hold lcd_busy=1 for 50 cycles during a refresh. Required: no strobe while busy=1; the next strobe comes in the first cycle after busy falls (plus the state step); the strobe is never wider than 1 cycle.
4. Write during refresh. Stimulus: write addr=0 char=0x5A while line 1 is being sent. Required: the current refresh completes with 0x20 at addr 0, then a second full refresh shows 0x5A at position 0.
5. Clear collision. Stimulus: clear and wr_en addr=5 char=0x31 in the same cycle. Required: the next refresh shows 0x31 at position 5 and 0x20 elsewhere.
6. Reset mid-refresh. Stimulus: assert rst during CHAR col 7. Required: strobe stops, init_done=0, 10-cycle PWRUP, full init repeated, then a refresh of all 0x20.
